seq_1001_frame_tx: RTL and testbench

//  Serial frame transmitter; the transmit end of the 1001 sync-marker link.

---
 rtl/seq_1001_frame_tx.sv | 156 +++++++++++++++
 tb/tb_seq_1001_frame_tx.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_1001_frame_tx.sv
// Serial frame transmitter: preamble 1001, then a stuffed MSB-first payload.
// Optional even-parity bit after the payload when FRAME_PARITY_EN is defined.
module seq_1001_frame_tx #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_ready,
  output logic              sout,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [3:0] PRE_PAT = 4'b1001;

`ifdef FRAME_PARITY_EN
  typedef enum logic [1:0] {IDLE, PRE, DATA, PAR} state_t;
`else
  typedef enum logic [1:0] {IDLE, PRE, DATA} state_t;
`endif

  state_t            state_reg, state_next;
  logic [1:0]        pre_idx_reg, pre_idx_next;
  logic [DATA_W-1:0] shift_reg, shift_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [2:0]        hist_reg, hist_next;
  logic              sout_reg, sout_next;
  logic              busy_reg, busy_next;
  logic              done_reg, done_next;
  logic              ready_reg, ready_next;
  logic              pre_bit;
  logic              data_bit;
`ifdef FRAME_PARITY_EN
  logic              par_reg, par_next;
`endif

  assign pre_bit  = PRE_PAT[2'd3 - pre_idx_reg];
  assign data_bit = shift_reg[DATA_W-1];

  always_comb begin
    state_next   = state_reg;
    pre_idx_next = pre_idx_reg;
    shift_next   = shift_reg;
    cnt_next     = cnt_reg;
    hist_next    = hist_reg;
    sout_next    = sout_reg;
    busy_next    = busy_reg;
    done_next    = 1'b0;
    ready_next   = ready_reg;
`ifdef FRAME_PARITY_EN
    par_next     = par_reg;
`endif
    case (state_reg)
      IDLE: begin
        // ready_reg is low in the cycle right after done, which forces one idle gap
        if (ready_reg && tx_valid) begin
          state_next   = PRE;
          shift_next   = tx_data;
          cnt_next     = CNT_W'(DATA_W);
          pre_idx_next = 2'd1;
          sout_next    = 1'b1;
          hist_next    = {hist_reg[1:0], 1'b1};
          busy_next    = 1'b1;
          ready_next   = 1'b0;
`ifdef FRAME_PARITY_EN
          par_next     = ^tx_data;
`endif
        end else begin
          sout_next  = 1'b0;
          busy_next  = 1'b0;
          ready_next = 1'b1;
          hist_next  = 3'b000;
        end
      end
      PRE: begin
        sout_next    = pre_bit;
        hist_next    = {hist_reg[1:0], pre_bit};
        pre_idx_next = pre_idx_reg + 2'd1;
        if (pre_idx_reg == 2'd3) state_next = DATA;
      end
      DATA: begin
        // A 1 after history 100 would recreate the marker, so insert a 0 first
        if (hist_reg == 3'b100 && data_bit) begin
          sout_next = 1'b0;
          hist_next = 3'b000;
        end else begin
          sout_next  = data_bit;
          hist_next  = {hist_reg[1:0], data_bit};
          shift_next = shift_reg << 1;
          cnt_next   = cnt_reg - CNT_W'(1);
          if (cnt_reg == CNT_W'(1)) begin
`ifdef FRAME_PARITY_EN
            state_next = PAR;
`else
            state_next = IDLE;
            done_next  = 1'b1;
`endif
          end
        end
      end
`ifdef FRAME_PARITY_EN
      PAR: begin
        if (hist_reg == 3'b100 && par_reg) begin
          sout_next = 1'b0;
          hist_next = 3'b000;
        end else begin
          sout_next  = par_reg;
          hist_next  = {hist_reg[1:0], par_reg};
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg   <= IDLE;
      pre_idx_reg <= 2'd0;
      shift_reg   <= '0;
      cnt_reg     <= '0;
      hist_reg    <= 3'b000;
      sout_reg    <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      ready_reg   <= 1'b1;
`ifdef FRAME_PARITY_EN
      par_reg     <= 1'b0;
`endif
    end else begin
      state_reg   <= state_next;
      pre_idx_reg <= pre_idx_next;
      shift_reg   <= shift_next;
      cnt_reg     <= cnt_next;
      hist_reg    <= hist_next;
      sout_reg    <= sout_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
      ready_reg   <= ready_next;
`ifdef FRAME_PARITY_EN
      par_reg     <= par_next;
`endif
    end
  end

  assign tx_ready = ready_reg;
  assign sout     = sout_reg;
  assign busy     = busy_reg;
  assign done     = done_reg;

endmodule

// File: tb/tb_seq_1001_frame_tx.sv
// Scoreboard bench for seq_1001_frame_tx; expected serial bits are queued at
// handshake and popped one per cycle. Honours FRAME_PARITY_EN like the design.
module tb_seq_1001_frame_tx;

  localparam int DATA_W = 8;
`ifdef FRAME_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              tx_valid = 1'b0;
  logic [DATA_W-1:0] tx_data = '0;
  logic              tx_ready, sout, busy, done;

  int n_checks = 0;
  int n_fail   = 0;
  logic exp_q[$];

  seq_1001_frame_tx #(.DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .sout(sout), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  // Reference frame: preamble, then payload with the 100+1 stuffing rule
  task automatic build_expected(input logic [DATA_W-1:0] d);
    logic [2:0] h;
    logic p;
    h = 3'b001;
    p = 1'b0;
    exp_q.push_back(1'b1); exp_q.push_back(1'b0);
    exp_q.push_back(1'b0); exp_q.push_back(1'b1);
    for (int i = DATA_W - 1; i >= 0; i--) begin
      if (h == 3'b100 && d[i]) begin
        exp_q.push_back(1'b0);
        h = 3'b000;
      end
      exp_q.push_back(d[i]);
      h = {h[1:0], d[i]};
      p = p ^ d[i];
    end
`ifdef FRAME_PARITY_EN
    if (h == 3'b100 && p) exp_q.push_back(1'b0);
    exp_q.push_back(p);
`endif
  endtask

  // Starts and ends just after a negedge. abort_at>0 pulls rst low after that many bits.
  task automatic send_frame(input logic [DATA_W-1:0] d, input bit noise, input int abort_at,
                            output int cycles, output logic [31:0] obs);
    int dets;
    logic [3:0] w;
    logic b;
    logic last;
    cycles = 0; obs = '0; dets = 0; w = 4'b0000;
    n_checks++;
    if (tx_ready !== 1'b1) begin
      n_fail++; $display("FAIL ready_idle: got %b want 1", tx_ready);
    end
    tx_valid = 1'b1;
    tx_data  = d;
    build_expected(d);
    @(negedge clk);
    tx_data  = ~d;
    tx_valid = 1'b0;
    while (exp_q.size() > 0) begin
      b = exp_q.pop_front();
      last = (exp_q.size() == 0);
      cycles++;
      n_checks++;
      if (sout !== b) begin
        n_fail++; $display("FAIL sout_bit%0d data=%h: got %b want %b", cycles, d, sout, b);
      end
      n_checks++;
      if (busy !== 1'b1) begin
        n_fail++; $display("FAIL busy_bit%0d: got %b want 1", cycles, busy);
      end
      n_checks++;
      if (done !== last) begin
        n_fail++; $display("FAIL done_bit%0d: got %b want %b", cycles, done, last);
      end
      n_checks++;
      if (tx_ready !== 1'b0) begin
        n_fail++; $display("FAIL ready_busy%0d: got %b want 0", cycles, tx_ready);
      end
      obs = {obs[30:0], sout};
      w   = {w[2:0], sout};
      if (w == 4'b1001) dets++;
      if (abort_at > 0 && cycles == abort_at) begin
        rst = 1'b0;
        tx_valid = 1'b0;
        exp_q.delete();
        @(negedge clk);
        n_checks++;
        if (sout !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || tx_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL abort_idle: got sout=%b busy=%b done=%b ready=%b want 0 0 0 1",
                   sout, busy, done, tx_ready);
        end
        rst = 1'b1;
        $display("frame %h aborted after %0d bits", d, cycles);
        return;
      end
      tx_valid = (noise && !last) ? 1'($urandom_range(0, 1)) : 1'b0;
      tx_data  = DATA_W'($urandom);
      @(negedge clk);
    end
    n_checks++;
    if (sout !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || tx_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL post_frame: got sout=%b busy=%b done=%b ready=%b want 0 0 0 1",
               sout, busy, done, tx_ready);
    end
    n_checks++;
    if (dets != 1) begin
      n_fail++; $display("FAIL detector_count data=%h: got %0d want 1", d, dets);
    end
    $display("frame %h: %0d bits, serial %b", d, cycles, obs[15:0]);
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (sout !== 1'b0) begin n_fail++; $display("FAIL reset_sout: got %b want 0", sout); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_checks++;
    if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", tx_ready); end
    rst = 1'b1;
    @(negedge clk);
    $display("reset released");
  endtask

  task automatic test_zero;
    int cyc; logic [31:0] obs;
    send_frame(8'h00, 1'b0, 0, cyc, obs);
    n_checks++;
    if (cyc != 12 + PB) begin n_fail++; $display("FAIL zero_len: got %0d want %0d", cyc, 12 + PB); end
`ifndef FRAME_PARITY_EN
    n_checks++;
    if (obs[11:0] !== 12'b1001_0000_0000) begin
      n_fail++; $display("FAIL zero_pattern: got %b want 100100000000", obs[11:0]);
    end
`endif
  endtask

  task automatic test_stuffing;
    int cyc; logic [31:0] obs;
    send_frame(8'h24, 1'b0, 0, cyc, obs);
    n_checks++;
    if (cyc != 14 + PB) begin n_fail++; $display("FAIL stuff_len: got %0d want %0d", cyc, 14 + PB); end
`ifndef FRAME_PARITY_EN
    n_checks++;
    if (obs[13:0] !== 14'b10010001000100) begin
      n_fail++; $display("FAIL stuff_pattern: got %b want 10010001000100", obs[13:0]);
    end
`endif
  endtask

  task automatic test_boundary;
    int cyc; logic [31:0] obs;
    send_frame(8'h90, 1'b0, 0, cyc, obs);
    n_checks++;
    if (cyc != 13 + PB) begin n_fail++; $display("FAIL boundary_len: got %0d want %0d", cyc, 13 + PB); end
`ifndef FRAME_PARITY_EN
    n_checks++;
    if (obs[12:0] !== 13'b1001100010000) begin
      n_fail++; $display("FAIL boundary_pattern: got %b want 1001100010000", obs[12:0]);
    end
`endif
  endtask

  task automatic test_reset_midframe;
    int cyc; logic [31:0] obs;
    send_frame(8'hA5, 1'b1, 6, cyc, obs);
    send_frame(8'h3C, 1'b1, 0, cyc, obs);
  endtask

  task automatic test_back_to_back;
    int cyc; logic [31:0] obs;
    send_frame(8'hFF, 1'b1, 0, cyc, obs);
    send_frame(8'h49, 1'b1, 0, cyc, obs);
    for (int k = 0; k < 6; k++) send_frame(DATA_W'($urandom), 1'b1, 0, cyc, obs);
  endtask

`ifdef FRAME_PARITY_EN
  task automatic test_parity;
    int cyc; logic [31:0] obs;
    send_frame(8'h01, 1'b0, 0, cyc, obs);
    n_checks++;
    if (cyc != 13) begin n_fail++; $display("FAIL parity_len: got %0d want 13", cyc); end
    n_checks++;
    if (obs[12:0] !== 13'b1001000000011) begin
      n_fail++; $display("FAIL parity_pattern: got %b want 1001000000011", obs[12:0]);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_zero();
    test_stuffing();
    test_boundary();
    test_reset_midframe();
    test_back_to_back();
`ifdef FRAME_PARITY_EN
    test_parity();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
